lane_traffic_engine: RTL

Multi-car traffic generator for one road lane. It is the parametrised successor of the single-car mover. It holds NUM_CARS car positions with a configurable direction and run-time speed, and updates them once per video frame using a time-multiplexed, one-car-per-clock state machine. In the same pass it checks each car against the frog's horizontal span and reports a registered hit to the game-logic block.

---
 rtl/lane_traffic_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lane_traffic_engine.sv
// lane_traffic_engine
// Multi-car traffic generator for one road lane. Holds NUM_CARS car positions
// in lane coordinates [0, SPAN) and, once per accepted frame_tick, walks the
// cars one per clock: moves each by 'speed' (wrapping modulo SPAN) and checks
// the moved car against the frog's horizontal span. The OR of all per-car hits
// is published on 'hit' when the pass finishes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for frame_tick && run
// ST_UPDATE | moving / collision-checking car 'idx', one car per cycle
// ST_DONE   | one-cycle end-of-pass; hit and done are valid here
module lane_traffic_engine #(
    parameter int NUM_CARS     = 4,
    parameter int SCREEN_WIDTH = 640,
    parameter int CAR_WIDTH    = 32,
    parameter int FROG_WIDTH   = 32,
    parameter int SPACING      = 168,
    parameter int DIR          = 0,
    parameter int SPEED_W      = 4,
    parameter int X_W          = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    run,
    input  logic                    load,
    input  logic [SPEED_W-1:0]      speed,
    input  logic [X_W-1:0]          frog_x,
    input  logic                    frog_in_lane,
    output logic [NUM_CARS*X_W-1:0] car_x,
    output logic                    busy,
    output logic                    done,
    output logic                    hit,
    output logic                    overrun
);

    localparam int SPAN  = SCREEN_WIDTH + CAR_WIDTH;
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);
    localparam logic [X_W:0]     SPAN_E   = (X_W+1)'(SPAN);
    // A car at x' overlaps the frog when frog_x < x' < frog_x + FROG_WIDTH + CAR_WIDTH,
    // because car lane coordinates are offset by CAR_WIDTH from screen pixels.
    localparam logic [X_W+1:0]   REACH    = (X_W+2)'(FROG_WIDTH + CAR_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [X_W-1:0]     pos [NUM_CARS];
    logic [X_W-1:0]     cur_x;
    logic [X_W-1:0]     new_x;
    logic [X_W:0]       cur_e;
    logic [X_W:0]       spd_e;
    logic [X_W:0]       sum_e;
    logic [X_W+1:0]     frog_e;
    logic [X_W+1:0]     new_e;
    logic               hit_acc;
    logic               hit_now;
    logic               last_car;

    // Select the position of the car currently being processed.
    always_comb begin
        cur_x = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_x = pos[i];
            end
        end
    end

    // Move the selected car by 'speed', wrapping exactly modulo SPAN.
    always_comb begin
        cur_e = {1'b0, cur_x};
        spd_e = (X_W+1)'(speed);
        sum_e = cur_e + spd_e;
        new_x = cur_x;
        if (DIR == 0) begin
            if (cur_e >= spd_e) begin
                new_x = X_W'(cur_e - spd_e);
            end else begin
                new_x = X_W'(cur_e + SPAN_E - spd_e);
            end
        end else begin
            if (sum_e >= SPAN_E) begin
                new_x = X_W'(sum_e - SPAN_E);
            end else begin
                new_x = sum_e[X_W-1:0];
            end
        end
    end

    // Collision of the moved car with the frog, in widened arithmetic.
    always_comb begin
        frog_e  = (X_W+2)'(frog_x);
        new_e   = (X_W+2)'(new_x);
        hit_now = frog_in_lane && (frog_e < new_e) && ((frog_e + REACH) > new_e);
    end

    assign last_car = (idx == LAST_IDX);

    // Next-state logic; load forces the FSM home from any state.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (frame_tick && run) begin
                    next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (last_car) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (load) begin
            next_state = ST_IDLE;
        end
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
            done  <= (next_state == ST_DONE);
        end
    end

    // Car positions, pass index, hit accumulation and overrun tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                pos[i] <= X_W'(i * SPACING);
            end
            idx     <= '0;
            hit_acc <= 1'b0;
            hit     <= 1'b0;
            overrun <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                pos[i] <= X_W'(i * SPACING);
            end
            idx     <= '0;
            hit_acc <= 1'b0;
            hit     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick && run) begin
                        idx     <= '0;
                        hit_acc <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    for (int i = 0; i < NUM_CARS; i++) begin
                        if (idx == IDX_W'(i)) begin
                            pos[i] <= new_x;
                        end
                    end
                    hit_acc <= hit_acc | hit_now;
                    if (last_car) begin
                        idx <= '0;
                        hit <= hit_acc | hit_now;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (frame_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Flatten the position registers onto the output bus.
    always_comb begin
        car_x = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            car_x[i*X_W +: X_W] = pos[i];
        end
    end

endmodule
